// File: rtl/sat_pkg.sv
// Shared SAT-accelerator definitions.
// Holds the literal/clause geometry, the packed clause type and the
// dispatch controller state encoding used by the clause scheduling logic.
package sat_pkg;

  localparam int ELEMENT_CNT     = 1024;
  localparam int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1;
  localparam int CLAUSE_WIDTH    = 4;

  typedef logic [CLAUSE_WIDTH-1:0][ELEMENT_BIT_CNT-1:0] clause_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    DRAIN    = 2'd2
  } dispatch_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker, purely combinational.
// Ports:
//   eligible  - per-requester eligibility vector
//   ptr       - index that has highest priority this cycle
//   grant     - one-hot grant (zero when nothing is eligible)
//   grant_idx - binary index of the granted requester
//   any_grant - at least one requester is eligible
// N must be a power of two so that index arithmetic wraps modulo N.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_grant
);

  localparam int IW = $clog2(N);

  logic [2*N-1:0] doubled;
  logic [2*N-1:0] shifted;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;

  // Rotate so that ptr lands at bit 0, pick the lowest set bit, then add
  // ptr back to return to the original index space.
  always_comb begin
    doubled = {eligible, eligible};
    shifted = doubled >> ptr;
    rotated = shifted[N-1:0];
    offset  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = i[IW-1:0];
    end
    any_grant = |eligible;
    grant_idx = ptr + offset;
    grant     = any_grant ? ({{(N-1){1'b0}}, 1'b1} << grant_idx) : '0;
  end

endmodule

// File: rtl/clause_dispatch_ctrl.sv
// Credit-based clause dispatcher.
// Moves clauses from the upstream stream into NUM_ENG engine queues. Each
// engine has a credit counter tracking free queue slots; the target engine
// is chosen round-robin among engines with credit. A start/flush/drain
// sequence lets the host quiesce all engines before loading a new problem.
// Ports:
//   clock, reset (sync, active-low)
//   start_in, flush_in          - host control
//   clause_in, clause_valid_in  - upstream clause stream
//   clause_ready_out            - combinational accept indication
//   deq_in                      - per-engine pop, returns one credit
//   clause_out, push_out        - registered clause and one-hot write strobe
//   busy_out, drained_out       - not idle / one-cycle drain-complete pulse
//   err_out                     - sticky credit overflow
//   dispatch_cnt_out            - clauses dispatched since reset (wraps)
module clause_dispatch_ctrl #(
  parameter int NUM_ENG         = 4,
  parameter int CLAUSE_WIDTH    = 4,
  parameter int ELEMENT_BIT_CNT = 11,
  parameter int QUEUE_DEPTH     = 8,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    start_in,
  input  logic                                    flush_in,
  input  logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_in,
  input  logic                                    clause_valid_in,
  output logic                                    clause_ready_out,
  input  logic [NUM_ENG-1:0]                      deq_in,
  output logic [CLAUSE_WIDTH*ELEMENT_BIT_CNT-1:0] clause_out,
  output logic [NUM_ENG-1:0]                      push_out,
  output logic                                    busy_out,
  output logic                                    drained_out,
  output logic                                    err_out,
  output logic [CNT_WIDTH-1:0]                    dispatch_cnt_out
);

  import sat_pkg::dispatch_state_e;
  import sat_pkg::IDLE;
  import sat_pkg::DISPATCH;
  import sat_pkg::DRAIN;

  localparam int IW = $clog2(NUM_ENG);
  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  dispatch_state_e state, state_next;

  logic [CW-1:0]      credit [NUM_ENG];
  logic [IW-1:0]      rr_ptr;
  logic [NUM_ENG-1:0] eligible;
  logic [NUM_ENG-1:0] grant;
  logic [NUM_ENG-1:0] grant_vec;
  logic [IW-1:0]      grant_idx;
  logic               any_grant;
  logic               accept;
  logic               all_full;
  logic               drain_done;

  // Eligibility is taken from registered credit only; a same-cycle deq_in
  // does not make an empty engine eligible until the next cycle.
  always_comb begin
    all_full = 1'b1;
    for (int i = 0; i < NUM_ENG; i++) begin
      eligible[i] = (credit[i] != '0);
      if (credit[i] != FULL) all_full = 1'b0;
    end
  end

  rr_pick #(.N(NUM_ENG)) u_rr_pick (
    .eligible  (eligible),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // flush_in wins over an accept in the same cycle.
  assign clause_ready_out = (state == DISPATCH) && !flush_in && any_grant;
  assign accept           = clause_valid_in && clause_ready_out;
  assign grant_vec        = accept ? grant : '0;
  assign drain_done       = (state == DRAIN) && all_full && (push_out == '0);
  assign busy_out         = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_in)   state_next = DISPATCH;
      DISPATCH: if (flush_in)   state_next = DRAIN;
      DRAIN:    if (drain_done) state_next = IDLE;
      default:                  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_ptr           <= '0;
      clause_out       <= '0;
      push_out         <= '0;
      drained_out      <= 1'b0;
      err_out          <= 1'b0;
      dispatch_cnt_out <= '0;
      for (int i = 0; i < NUM_ENG; i++) credit[i] <= FULL;
    end else begin
      push_out    <= grant_vec;
      drained_out <= drain_done;
      if (accept) begin
        clause_out       <= clause_in;
        rr_ptr           <= grant_idx + IW'(1);
        dispatch_cnt_out <= dispatch_cnt_out + CNT_WIDTH'(1);
      end
      // Grant and deq on the same engine cancel out. A deq on a full
      // counter saturates and flags the sticky error.
      for (int i = 0; i < NUM_ENG; i++) begin
        if (grant_vec[i] && !deq_in[i]) begin
          credit[i] <= credit[i] - CW'(1);
        end else if (deq_in[i] && !grant_vec[i]) begin
          if (credit[i] == FULL) err_out   <= 1'b1;
          else                   credit[i] <= credit[i] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_clause_dispatch_ctrl.sv
module tb_clause_dispatch_ctrl;

  localparam int NE = 4;
  localparam int QD = 8;
  localparam int DW = 44;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start_in = 1'b0;
  logic          flush_in = 1'b0;
  logic [DW-1:0] clause_in = '0;
  logic          clause_valid_in = 1'b0;
  logic          clause_ready_out;
  logic [NE-1:0] deq_in = '0;
  logic [DW-1:0] clause_out;
  logic [NE-1:0] push_out;
  logic          busy_out;
  logic          drained_out;
  logic          err_out;
  logic [15:0]   dispatch_cnt_out;

  always #5 clock = ~clock;

  clause_dispatch_ctrl #(
    .NUM_ENG(NE), .CLAUSE_WIDTH(4), .ELEMENT_BIT_CNT(11),
    .QUEUE_DEPTH(QD), .CNT_WIDTH(16)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start_in         (start_in),
    .flush_in         (flush_in),
    .clause_in        (clause_in),
    .clause_valid_in  (clause_valid_in),
    .clause_ready_out (clause_ready_out),
    .deq_in           (deq_in),
    .clause_out       (clause_out),
    .push_out         (push_out),
    .busy_out         (busy_out),
    .drained_out      (drained_out),
    .err_out          (err_out),
    .dispatch_cnt_out (dispatch_cnt_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: 0=idle, 1=dispatching, 2=draining.
  int            m_state;
  int            m_credit [NE];
  int            m_ptr;
  int            m_cnt;
  bit            m_err;
  bit            m_drained;
  logic [NE-1:0] m_push;
  logic [DW-1:0] m_clause;
  bit            obs_ready;
  bit            exp_ready;

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_cnt = 0; m_err = 0; m_drained = 0;
    m_push = '0; m_clause = '0;
    for (int e = 0; e < NE; e++) m_credit[e] = QD;
  endtask

  task automatic do_reset(input bit v);
    reset = 1'b0; start_in = 1'b0; flush_in = 1'b0;
    clause_valid_in = v; clause_in = 44'hABC_DEF0_1234; deq_in = '0;
    @(posedge clock); #1;
    reset = 1'b1; clause_valid_in = 1'b0;
    model_reset();
  endtask

  // Drive one cycle of inputs, capture ready, advance the reference model.
  task automatic tick(input bit st, input bit fl, input bit v,
                      input logic [DW-1:0] c, input logic [NE-1:0] d);
    int  g;
    bit  acc;
    bit  full;
    start_in = st; flush_in = fl; clause_valid_in = v; clause_in = c; deq_in = d;
    #1;
    obs_ready = clause_ready_out;
    exp_ready = 0;
    if (m_state == 1 && !fl)
      for (int e = 0; e < NE; e++) if (m_credit[e] > 0) exp_ready = 1;
    acc = v && exp_ready;
    g = -1;
    if (acc)
      for (int k = 0; k < NE; k++)
        if (g < 0 && m_credit[(m_ptr + k) % NE] > 0) g = (m_ptr + k) % NE;
    full = 1;
    for (int e = 0; e < NE; e++) if (m_credit[e] != QD) full = 0;
    m_drained = 0;
    case (m_state)
      0: if (st) m_state = 1;
      1: if (fl) m_state = 2;
      default: if (full && m_push == '0) begin m_state = 0; m_drained = 1; end
    endcase
    for (int e = 0; e < NE; e++) begin
      if (g == e && d[e]) ;
      else if (g == e) m_credit[e]--;
      else if (d[e]) begin
        if (m_credit[e] == QD) m_err = 1;
        else m_credit[e]++;
      end
    end
    m_push = '0;
    if (acc) begin
      m_push[g] = 1'b1;
      m_clause = c;
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (g + 1) % NE;
    end
    @(posedge clock); #1;
  endtask

  function automatic logic [DW-1:0] rnd_clause();
    return {12'($urandom()), $urandom()};
  endfunction

  task automatic test_reset();
    do_reset(1'b0);
    n_checks++; if (push_out !== '0) begin n_fail++; $display("FAIL reset_push got %b want 0", push_out); end
    n_checks++; if (clause_out !== '0) begin n_fail++; $display("FAIL reset_clause got %h want 0", clause_out); end
    n_checks++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_out); end
    n_checks++; if (drained_out !== 1'b0 || err_out !== 1'b0) begin n_fail++; $display("FAIL reset_flags got drained=%b err=%b want 0 0", drained_out, err_out); end
    n_checks++; if (dispatch_cnt_out !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", dispatch_cnt_out); end
    n_checks++; if (clause_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", clause_ready_out); end
  endtask

  task automatic test_basic();
    logic [NE-1:0] want;
    do_reset(1'b0);
    tick(1, 0, 0, '0, '0);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 1, 44'h123_4567_89AB, '0);
      want = 4'b0001 << k;
      n_checks++; if (push_out !== want) begin n_fail++; $display("FAIL basic_push%0d got %b want %b", k, push_out, want); end
      n_checks++; if (clause_out !== 44'h123_4567_89AB) begin n_fail++; $display("FAIL basic_clause%0d got %h want 123456789ab", k, clause_out); end
    end
    tick(0, 0, 0, '0, '0);
    n_checks++; if (push_out !== '0) begin n_fail++; $display("FAIL basic_idle_push got %b want 0", push_out); end
    n_checks++; if (dispatch_cnt_out !== 16'd4) begin n_fail++; $display("FAIL basic_cnt got %0d want 4", dispatch_cnt_out); end
  endtask

  task automatic test_exhaust();
    int n_acc;
    do_reset(1'b0);
    tick(1, 0, 0, '0, '0);
    n_acc = 0;
    for (int k = 0; k < 36; k++) begin
      tick(0, 0, 1, rnd_clause(), '0);
      if (obs_ready) n_acc++;
    end
    n_checks++; if (n_acc != 32) begin n_fail++; $display("FAIL exhaust_accepts got %0d want 32", n_acc); end
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_ready got %b want 0", obs_ready); end
    tick(0, 0, 1, rnd_clause(), 4'b0100);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_nobypass got %b want 0", obs_ready); end
    tick(0, 0, 1, 44'h0AA_5555_AAAA, '0);
    n_checks++; if (push_out !== 4'b0100) begin n_fail++; $display("FAIL exhaust_push2 got %b want 0100", push_out); end
    n_checks++; if (clause_out !== m_clause) begin n_fail++; $display("FAIL exhaust_clause got %h want %h", clause_out, m_clause); end
    tick(0, 0, 1, rnd_clause(), '0);
    n_checks++; if (push_out !== '0 || obs_ready !== 1'b0) begin n_fail++; $display("FAIL exhaust_after got push=%b ready=%b want 0 0", push_out, obs_ready); end
  endtask

  task automatic test_same_cycle();
    do_reset(1'b0);
    tick(1, 0, 0, '0, '0);
    for (int k = 0; k < 28; k++) tick(0, 0, 1, rnd_clause(), '0);
    tick(0, 0, 1, rnd_clause(), 4'b0001);
    n_checks++; if (push_out !== 4'b0001) begin n_fail++; $display("FAIL same_push0 got %b want 0001", push_out); end
    for (int k = 1; k < 4; k++) tick(0, 0, 1, rnd_clause(), '0);
    tick(0, 0, 1, rnd_clause(), '0);
    n_checks++; if (obs_ready !== 1'b1) begin n_fail++; $display("FAIL same_eligible got %b want 1", obs_ready); end
    n_checks++; if (push_out !== 4'b0001) begin n_fail++; $display("FAIL same_regrant got %b want 0001", push_out); end
    tick(0, 0, 1, rnd_clause(), '0);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL same_empty got %b want 0", obs_ready); end
  endtask

  task automatic test_flush();
    logic [NE-1:0] order [6];
    int pulses;
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    do_reset(1'b0);
    tick(1, 0, 0, '0, '0);
    for (int k = 0; k < 6; k++) tick(0, 0, 1, rnd_clause(), '0);
    tick(0, 1, 1, rnd_clause(), '0);
    n_checks++; if (obs_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got %b want 0", obs_ready); end
    n_checks++; if (push_out !== '0 || busy_out !== 1'b1) begin n_fail++; $display("FAIL flush_state got push=%b busy=%b want 0 1", push_out, busy_out); end
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick(0, 0, 1, rnd_clause(), (k < 6) ? order[k] : 4'b0000);
      if (drained_out === 1'b1) pulses++;
      n_checks++; if (drained_out !== m_drained) begin n_fail++; $display("FAIL flush_drained%0d got %b want %b", k, drained_out, m_drained); end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL flush_pulses got %0d want 1", pulses); end
    n_checks++; if (busy_out !== 1'b0 || dispatch_cnt_out !== 16'd6) begin n_fail++; $display("FAIL flush_end got busy=%b cnt=%0d want 0 6", busy_out, dispatch_cnt_out); end
  endtask

  task automatic test_overflow();
    int n_acc;
    do_reset(1'b0);
    tick(0, 1, 0, '0, 4'b0010);
    n_checks++; if (err_out !== 1'b1 || busy_out !== 1'b0) begin n_fail++; $display("FAIL ovf_err got err=%b busy=%b want 1 0", err_out, busy_out); end
    for (int k = 0; k < 3; k++) tick(0, 0, 0, '0, '0);
    n_checks++; if (err_out !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", err_out); end
    tick(1, 0, 0, '0, '0);
    n_acc = 0;
    for (int k = 0; k < 40; k++) begin
      tick(0, 0, 1, rnd_clause(), '0);
      if (obs_ready) n_acc++;
    end
    n_checks++; if (n_acc != 32) begin n_fail++; $display("FAIL ovf_saturate got %0d accepts want 32", n_acc); end
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    tick(1, 0, 0, '0, '0);
    for (int k = 0; k < 5; k++) tick(0, 0, 1, rnd_clause(), 4'b0000);
    do_reset(1'b1);
    n_checks++; if (push_out !== '0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL mid_state got push=%b busy=%b want 0 0", push_out, busy_out); end
    n_checks++; if (dispatch_cnt_out !== 16'd0 || clause_out !== '0) begin n_fail++; $display("FAIL mid_regs got cnt=%0d clause=%h want 0 0", dispatch_cnt_out, clause_out); end
    tick(1, 0, 0, '0, '0);
    tick(0, 0, 1, rnd_clause(), '0);
    n_checks++; if (push_out !== 4'b0001) begin n_fail++; $display("FAIL mid_rrptr got %b want 0001", push_out); end
  endtask

  task automatic test_random();
    logic [NE-1:0] d;
    bit st, fl;
    do_reset(1'b0);
    for (int k = 0; k < 400; k++) begin
      d = '0;
      for (int e = 0; e < NE; e++)
        if (m_credit[e] < QD && $urandom_range(0, 2) == 0) d[e] = 1'b1;
      st = ($urandom_range(0, 7) == 0);
      fl = ($urandom_range(0, 29) == 0);
      tick(st, fl, 1'($urandom_range(0, 1)), rnd_clause(), d);
      n_checks++; if (obs_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready@%0d got %b want %b", k, obs_ready, exp_ready); end
      n_checks++; if (push_out !== m_push) begin n_fail++; $display("FAIL rnd_push@%0d got %b want %b", k, push_out, m_push); end
      n_checks++; if (clause_out !== m_clause) begin n_fail++; $display("FAIL rnd_clause@%0d got %h want %h", k, clause_out, m_clause); end
      n_checks++; if (busy_out !== (m_state != 0) || drained_out !== m_drained) begin n_fail++; $display("FAIL rnd_ctrl@%0d got busy=%b drained=%b want %b %b", k, busy_out, drained_out, (m_state != 0), m_drained); end
      n_checks++; if (err_out !== m_err || dispatch_cnt_out !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_stat@%0d got err=%b cnt=%0d want %b %0d", k, err_out, dispatch_cnt_out, m_err, m_cnt); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_exhaust();
    test_same_cycle();
    test_flush();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
